// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Tracks shadow copies of the EX, MEM and WB pipeline stages for an
//   in-order pipeline. It decides each cycle whether the instruction sitting
//   in ID must stall because one of its source registers is still being
//   produced by an older instruction. It also exposes the MEM/WB shadow
//   destinations to the forwarding unit.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   issue_valid    ID stage holds a valid instruction
//   issue_dest     destination register of the ID instruction
//   issue_wb_en    ID instruction writes back
//   issue_mem_read ID instruction is a load
//   src1, src2     ID source registers
//   two_src        src2 is a real operand
//   forward_en     forwarding unit is active
//   flush          branch taken, kill the ID instruction
//   freeze         global memory stall, hold the pipeline
//   hazard         stall IF/ID this cycle (combinational)
//   mem_dest       shadow MEM destination
//   mem_wb_en      shadow MEM write-back enable
//   mem_read_out   shadow MEM load flag
//   wb_dest        shadow WB destination
//   wb_wb_en       shadow WB write-back enable
//   stall_count    saturating count of hazard stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [3:0]  issue_dest,
   input  logic        issue_wb_en,
   input  logic        issue_mem_read,
   input  logic [3:0]  src1,
   input  logic [3:0]  src2,
   input  logic        two_src,
   input  logic        forward_en,
   input  logic        flush,
   input  logic        freeze,
   output logic        hazard,
   output logic [3:0]  mem_dest,
   output logic        mem_wb_en,
   output logic        mem_read_out,
   output logic [3:0]  wb_dest,
   output logic        wb_wb_en,
   output logic [15:0] stall_count
);

   typedef struct packed {
      logic       valid;
      logic [3:0] dest;
      logic       wbEn;
      logic       memRead;
   } stage_t;

   stage_t      exStage_q, exStage_d;
   stage_t      memStage_q, memStage_d;
   // The WB stage never feeds a load-use check or any output, so its
   // load flag is not kept.
   logic        wbValid_q, wbValid_d;
   logic [3:0]  wbDest_q, wbDest_d;
   logic        wbWbEn_q, wbWbEn_d;
   logic [15:0] stallCount_q, stallCount_d;

   logic src1MatchEx, src2MatchEx, src1MatchMem, src2MatchMem;
   logic anyMatchEx, anyMatchMem;

   // A stage matches a register only if it holds a real instruction that
   // will actually write that register back.
   function automatic logic stageMatch(input stage_t s, input logic [3:0] r);
      return s.valid & s.wbEn & (s.dest == r);
   endfunction

   // Source comparison against the older stages. The ID instruction's own
   // destination is never compared, and a shared src1/src2 collapses into a
   // single OR so it can only ever produce one stall decision per cycle.
   always_comb begin
      src1MatchEx  = stageMatch(exStage_q, src1);
      src2MatchEx  = two_src & stageMatch(exStage_q, src2);
      src1MatchMem = stageMatch(memStage_q, src1);
      src2MatchMem = two_src & stageMatch(memStage_q, src2);
      anyMatchEx   = src1MatchEx | src2MatchEx;
      anyMatchMem  = src1MatchMem | src2MatchMem;
   end

   // Stall decision. With forwarding, only a load still in EX cannot be
   // bypassed in time. Without forwarding, anything in EX or MEM must drain
   // first. WB never stalls because the register file writes early in the
   // cycle. A flushed ID instruction never stalls.
   always_comb begin
      hazard = 1'b0;
      if (!flush && issue_valid) begin
         if (forward_en) begin
            hazard = anyMatchEx & exStage_q.memRead;
         end else begin
            hazard = anyMatchEx | anyMatchMem;
         end
      end
   end

   // Next-state for the shadow pipeline and the stall counter. Normally the
   // stages shift by one and EX takes either the issued instruction or a
   // bubble. Freeze holds everything, except that a simultaneous flush still
   // kills whatever is in EX. Stalls are only counted on edges that advance.
   always_comb begin
      exStage_d    = exStage_q;
      memStage_d   = memStage_q;
      wbValid_d    = wbValid_q;
      wbDest_d     = wbDest_q;
      wbWbEn_d     = wbWbEn_q;
      stallCount_d = stallCount_q;
      if (!freeze) begin
         wbValid_d  = memStage_q.valid;
         wbDest_d   = memStage_q.dest;
         wbWbEn_d   = memStage_q.wbEn;
         memStage_d = exStage_q;
         if (issue_valid && !hazard && !flush) begin
            exStage_d.valid   = 1'b1;
            exStage_d.dest    = issue_dest;
            exStage_d.wbEn    = issue_wb_en;
            exStage_d.memRead = issue_mem_read;
         end else begin
            exStage_d = '0;
         end
         if (hazard && (stallCount_q != 16'hFFFF)) begin
            stallCount_d = stallCount_q + 16'd1;
         end
      end else if (flush) begin
         exStage_d = '0;
      end
   end

   // State registers. Reset wins over freeze and flush and throws away
   // anything in flight, so the first edge after reset advances from an
   // all-bubble pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         exStage_q    <= '0;
         memStage_q   <= '0;
         wbValid_q    <= 1'b0;
         wbDest_q     <= 4'd0;
         wbWbEn_q     <= 1'b0;
         stallCount_q <= 16'd0;
      end else begin
         exStage_q    <= exStage_d;
         memStage_q   <= memStage_d;
         wbValid_q    <= wbValid_d;
         wbDest_q     <= wbDest_d;
         wbWbEn_q     <= wbWbEn_d;
         stallCount_q <= stallCount_d;
      end
   end

   // Registered shadow outputs. Enables are qualified by valid so a bubble
   // can never look like a pending write to the forwarding unit.
   always_comb begin
      mem_dest     = memStage_q.dest;
      mem_wb_en    = memStage_q.valid & memStage_q.wbEn;
      mem_read_out = memStage_q.valid & memStage_q.memRead;
      wb_dest      = wbDest_q;
      wb_wb_en     = wbValid_q & wbWbEn_q;
      stall_count  = stallCount_q;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Purpose:
//   Self-checking bench for hazard_scoreboard. A table of directed vectors
//   drives one cycle each. For every vector the combinational hazard output
//   is checked before the edge, and the registered outputs are checked just
//   after it. A hand-written sequence covers counter saturation and reset.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

   logic        clk;
   logic        rst;
   logic        issueValid;
   logic [3:0]  issueDest;
   logic        issueWbEn;
   logic        issueMemRead;
   logic [3:0]  src1;
   logic [3:0]  src2;
   logic        twoSrc;
   logic        forwardEn;
   logic        flush;
   logic        freeze;
   logic        hazard;
   logic [3:0]  memDest;
   logic        memWbEn;
   logic        memReadOut;
   logic [3:0]  wbDest;
   logic        wbWbEn;
   logic [15:0] stallCount;

   int checks;
   int failures;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [3:0]  dest;
      logic        wb;
      logic        mr;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        two;
      logic        fwd;
      logic        fl;
      logic        frz;
      logic        expHazard;
      logic [3:0]  expMemDest;
      logic        expMemWbEn;
      logic        expMemRead;
      logic [3:0]  expWbDest;
      logic        expWbWbEn;
      logic [15:0] expCount;
   } vec_t;

   localparam int NumVecs = 30;
   vec_t vecs [NumVecs];

   hazard_scoreboard dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issueValid),
      .issue_dest    (issueDest),
      .issue_wb_en   (issueWbEn),
      .issue_mem_read(issueMemRead),
      .src1          (src1),
      .src2          (src2),
      .two_src       (twoSrc),
      .forward_en    (forwardEn),
      .flush         (flush),
      .freeze        (freeze),
      .hazard        (hazard),
      .mem_dest      (memDest),
      .mem_wb_en     (memWbEn),
      .mem_read_out  (memReadOut),
      .wb_dest       (wbDest),
      .wb_wb_en      (wbWbEn),
      .stall_count   (stallCount)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input int r, input int iv, input int dest, input int wb, input int mr,
      input int s1, input int s2, input int two, input int fwd,
      input int fl, input int frz,
      input int hz, input int md, input int mw, input int mrd,
      input int wd, input int ww, input int cnt);
      vec_t v;
      v.rst        = 1'(r);
      v.iv         = 1'(iv);
      v.dest       = 4'(dest);
      v.wb         = 1'(wb);
      v.mr         = 1'(mr);
      v.s1         = 4'(s1);
      v.s2         = 4'(s2);
      v.two        = 1'(two);
      v.fwd        = 1'(fwd);
      v.fl         = 1'(fl);
      v.frz        = 1'(frz);
      v.expHazard  = 1'(hz);
      v.expMemDest = 4'(md);
      v.expMemWbEn = 1'(mw);
      v.expMemRead = 1'(mrd);
      v.expWbDest  = 4'(wd);
      v.expWbWbEn  = 1'(ww);
      v.expCount   = 16'(cnt);
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst          = v.rst;
      issueValid   = v.iv;
      issueDest    = v.dest;
      issueWbEn    = v.wb;
      issueMemRead = v.mr;
      src1         = v.s1;
      src2         = v.s2;
      twoSrc       = v.two;
      forwardEn    = v.fwd;
      flush        = v.fl;
      freeze       = v.frz;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkRegs(input string tag, input logic [3:0] md,
                            input logic mw, input logic mrd,
                            input logic [3:0] wd, input logic ww,
                            input logic [15:0] cnt);
      checkOutput({tag, " mem_dest"},     16'(memDest),    16'(md));
      checkOutput({tag, " mem_wb_en"},    16'(memWbEn),    16'(mw));
      checkOutput({tag, " mem_read_out"}, 16'(memReadOut), 16'(mrd));
      checkOutput({tag, " wb_dest"},      16'(wbDest),     16'(wd));
      checkOutput({tag, " wb_wb_en"},     16'(wbWbEn),     16'(ww));
      checkOutput({tag, " stall_count"},  stallCount,      cnt);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      //              rst iv dst wb mr s1 s2 two fwd fl frz | hz md mw mr wd ww cnt
      // Load-use with forwarding: one stall cycle.
      vecs[0]  = mk(0, 1, 3, 1, 1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 1, 4, 1, 0, 3, 0, 0, 1, 0, 0,   1, 3, 1, 1, 0, 0, 1);
      vecs[2]  = mk(0, 1, 4, 1, 0, 3, 0, 0, 1, 0, 0,   0, 0, 0, 0, 3, 1, 1);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 4, 1, 0, 0, 0, 1);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 4, 1, 1);
      // No forwarding, dependency on src2: two stall cycles, WB ignored.
      vecs[5]  = mk(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
      vecs[6]  = mk(0, 1, 6, 1, 0, 1, 2, 1, 0, 0, 0,   1, 2, 1, 0, 0, 0, 2);
      vecs[7]  = mk(0, 1, 6, 1, 0, 1, 2, 1, 0, 0, 0,   1, 0, 0, 0, 2, 1, 3);
      vecs[8]  = mk(0, 1, 6, 1, 0, 1, 2, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 3);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 6, 1, 0, 0, 0, 3);
      // Self-reference, then src2 ignored when two_src=0.
      vecs[10] = mk(0, 1, 9, 1, 1, 9, 0, 0, 1, 0, 0,   0, 0, 0, 0, 6, 1, 3);
      vecs[11] = mk(0, 1, 1, 1, 0, 5, 9, 0, 1, 0, 0,   0, 9, 1, 1, 0, 0, 3);
      // src1 == src2, no forwarding: counted once per stall cycle.
      vecs[12] = mk(0, 1, 8, 1, 0, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 9, 1, 4);
      vecs[13] = mk(0, 1, 8, 1, 0, 1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1, 1, 5);
      vecs[14] = mk(0, 1, 8, 1, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 5);
      vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 8, 1, 0, 0, 0, 5);
      vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 8, 1, 5);
      // Flush kills the ID instruction; it never reaches MEM or WB.
      vecs[17] = mk(0, 1, 5, 1, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 5);
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 5);
      // Freeze with a load in EX and a consumer in ID.
      vecs[19] = mk(0, 1, 12, 1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 5);
      vecs[20] = mk(0, 1, 7, 1, 1, 0, 0, 0, 1, 0, 0,   0, 12, 1, 0, 0, 0, 5);
      vecs[21] = mk(0, 1, 10, 1, 0, 7, 0, 0, 1, 0, 1,  1, 12, 1, 0, 0, 0, 5);
      vecs[22] = mk(0, 1, 10, 1, 0, 7, 0, 0, 1, 0, 1,  1, 12, 1, 0, 0, 0, 5);
      vecs[23] = mk(0, 1, 10, 1, 0, 7, 0, 0, 1, 0, 1,  1, 12, 1, 0, 0, 0, 5);
      // Freeze plus flush: EX bubbled, MEM/WB held; bubble then drains.
      vecs[24] = mk(0, 1, 10, 1, 0, 7, 0, 0, 1, 1, 1,  0, 12, 1, 0, 0, 0, 5);
      vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 12, 1, 5);
      vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 5);
      // Reset over freeze discards the in-flight load and clears the count.
      vecs[27] = mk(0, 1, 3, 1, 1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 5);
      vecs[28] = mk(1, 1, 4, 1, 0, 3, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
      vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);

      // Initial reset from an unknown state.
      applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      checkRegs("reset", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0);
      checkOutput("reset hazard", 16'(hazard), 16'd0);

      for (int i = 0; i < NumVecs; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d hazard", i), 16'(hazard),
                     16'(vecs[i].expHazard));
         @(posedge clk);
         #1;
         checkRegs($sformatf("v%0d", i), vecs[i].expMemDest,
                   vecs[i].expMemWbEn, vecs[i].expMemRead,
                   vecs[i].expWbDest, vecs[i].expWbWbEn, vecs[i].expCount);
      end

      // Saturation: put ADD R2 in EX, preload the counter near its limit,
      // then hold a no-forwarding consumer of R2 for two stall cycles.
      @(negedge clk);
      applyStimulus(mk(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      @(negedge clk);
      applyStimulus(mk(0, 1, 6, 1, 0, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
      force dut.stallCount_q = 16'hFFFE;
      #1;
      release dut.stallCount_q;
      checkOutput("sat preload", stallCount, 16'hFFFE);
      checkOutput("sat hazard1", 16'(hazard), 16'd1);
      @(posedge clk);
      #1;
      checkOutput("sat reach", stallCount, 16'hFFFF);
      @(negedge clk);
      checkOutput("sat hazard2", 16'(hazard), 16'd1);
      @(posedge clk);
      #1;
      checkOutput("sat hold", stallCount, 16'hFFFF);
      checkOutput("sat mem_dest", 16'(memDest), 16'd0);
      checkOutput("sat wb_dest", 16'(wbDest), 16'd2);

      // One reset edge clears everything, including the saturated count.
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkRegs("final reset", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0);
      checkOutput("final reset hazard", 16'(hazard), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 The block SHALL have the input issue_valid (1 bit): the ID stage presents a valid instruction.
REQ-003 The block SHALL have the input issue_dest (4 bits): destination register of the ID-stage instruction.
REQ-004 The block SHALL have the inputs issue_wb_en (1 bit) and issue_mem_read (1 bit): the ID instruction writes back, and is a load.
REQ-005 The block SHALL have the inputs src1 and src2 (4 bits each): ID-stage source registers.
REQ-006 The block SHALL have the input two_src (1 bit): src2 is a real operand.
REQ-007 The block SHALL have the input forward_en (1 bit): the forwarding unit is active.
REQ-008 The block SHALL have the input flush (1 bit): branch taken, kill the ID instruction.
REQ-009 The block SHALL have the input freeze (1 bit): global memory stall, hold the pipeline.
REQ-010 The block SHALL have the output hazard (1 bit): stall ID/IF this cycle.
REQ-011 The block SHALL have the outputs mem_dest and wb_dest (4 bits each): shadow MEM/WB destinations, fed to forwarding.
REQ-012 The block SHALL have the outputs mem_wb_en, mem_read_out and wb_wb_en (1 bit each): shadow MEM/WB control.
REQ-013 The block SHALL have the output stall_count (16 bits): count of hazard stall cycles.

Function
REQ-014 The block SHALL keep three shadow stages, EX, MEM and WB, each holding {valid, dest[3:0], wb_en, mem_read}.
REQ-015 A stage SHALL "match" register r iff its valid=1, its wb_en=1 and its dest==r.
REQ-016 The block SHALL compute hazard combinationally in the same cycle; src1 is always checked, and src2 is checked only when two_src=1.
REQ-017 With forward_en=1: hazard SHALL be 1 iff issue_valid=1 AND a checked source matches EX AND EX.mem_read=1 (load-use).
REQ-018 With forward_en=0: hazard SHALL be 1 iff issue_valid=1 AND a checked source matches EX or MEM.
REQ-019 A WB-stage match SHALL never cause a hazard, because the register file writes in the first half of the cycle.
REQ-020 While flush=1, hazard SHALL be 0.
REQ-021 On each rising edge with rst=0 and freeze=0, the stages SHALL advance: WB<=MEM, MEM<=EX.
REQ-022 On each such edge, EX SHALL load the issue fields when issue_valid=1, hazard=0 and flush=0; otherwise EX SHALL load a bubble (all fields 0).
REQ-023 With freeze=1 and flush=0, all stages SHALL hold their values.
REQ-024 With freeze=1 and flush=1, EX SHALL become a bubble while MEM and WB hold.
REQ-025 stall_count SHALL increment by 1 on each edge where hazard=1 and freeze=0, and SHALL saturate at 16'hFFFF with no wrap.
REQ-026 mem_dest, mem_wb_en, mem_read_out, wb_dest and wb_wb_en SHALL be registered stage contents, with wb_en gated by valid.
REQ-027 Latency: an instruction issued on edge N SHALL appear in MEM after edge N+1 and in WB after edge N+2, with freeze cycles extending this 1:1.
REQ-028 The same register used as both src1 and src2 SHALL be checked once, with no double counting in stall_count.
REQ-029 An issue_dest equal to its own src1 SHALL NOT self-hazard; only older stages are compared.

Reset
REQ-030 While rst=1 at an edge, all stage fields, hazard-related state and stall_count SHALL clear to 0, so all outputs are 0 after that edge.
REQ-031 rst SHALL override freeze and flush, and SHALL discard any in-flight instruction.
REQ-032 The first edge with rst=0 SHALL behave as a normal advance from all-bubble stages.

Verification
REQ-033 Load-use test: forward_en=1; issue LDR R3 (dest=3, wb_en=1, mem_read=1); next cycle issue src1=3 -> hazard=1 for exactly 1 cycle, stall_count=1, then the instruction enters EX.
REQ-034 No-forwarding test: forward_en=0; issue ADD R2 (dest=2); next cycle src2=2, two_src=1 -> hazard=1 for 2 cycles, stall_count=2.
REQ-035 Freeze test: with a load in EX, hold freeze=1 for 3 cycles -> mem_dest unchanged, stall_count unchanged, and hazard still visible.
REQ-036 Flush test: flush=1 with issue_valid=1, dest=5 -> after the edge, EX is a bubble and 2 edges later wb_wb_en=0.
REQ-037 Saturation and reset test: preload stall_count to 16'hFFFE with hazard held -> it reaches 16'hFFFF and stays there; then rst=1 for one edge -> all outputs 0.
REQ-038 src2-ignore test: two_src=0, src2=EX.dest of a load, src1 unrelated -> hazard=0.
